// File: rtl/branch_history_table_pkg.sv
// Shared definitions for the branch history table.
// Contents: 2-bit counter encodings, the table initialisation value, the
// controller FSM state type, the MIPS opcodes the predictor cares about, and
// a helper that classifies an opcode as a trainable conditional branch.
package branch_history_table_pkg;

  // 2-bit saturating counter encodings; prediction is the MSB.
  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  // Every entry starts weakly not-taken so one taken outcome flips it.
  localparam logic [1:0] BHT_INIT_VAL = BHT_WNT;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bht_state_e;

  // MIPS primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BGEZ  = 6'h01;  // REGIMM group
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;

  // Only conditional branches train the table; jumps and ALU ops do not.
  function automatic logic is_cond_branch(input logic [5:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_BGEZ: hit = 1'b1;
      default:                                   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/branch_history_table_counter_update.sv
// bht_counter_update: combinational next state of one 2-bit saturating
// branch counter.
// Ports:
//   cnt      - current counter value
//   taken    - resolved branch outcome
//   cnt_next - counter after training (saturates at ST / SNT)
module bht_counter_update
  import branch_history_table_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != BHT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != BHT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// branch_history_table: direct-mapped table of 2-bit saturating counters used
// as a dynamic branch predictor at fetch, trained by resolved branches.
// Ports:
//   CLK, RST_N            - clock, asynchronous active-low reset
//   Ready                 - table initialised; fetch stalls while low
//   PredReq, PredPC       - prediction request from fetch
//   PredValid, PredTaken  - prediction, one cycle after PredReq
//   ResValid, ResPC, ResOP, ResTaken, ResPredicted - resolved instruction
//   Mispredict            - one-cycle pulse for a mispredicted branch
//   BranchCount, MispredCount - saturating statistics
//   dbg_state             - controller state (INIT/RUN) for observation
//
// Handshake: there is no backpressure. A request (PredReq or ResValid) is
// consumed in the cycle it is high provided Ready is high; otherwise it is
// dropped. PredValid is a one-cycle qualifier on PredTaken, Mispredict a
// one-cycle pulse, both one cycle after the consumed request.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int IDX_BITS  = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  output logic                 Ready,
  input  logic                 PredReq,
  input  logic [31:0]          PredPC,
  output logic                 PredValid,
  output logic                 PredTaken,
  input  logic                 ResValid,
  input  logic [31:0]          ResPC,
  input  logic [5:0]           ResOP,
  input  logic                 ResTaken,
  input  logic                 ResPredicted,
  output logic                 Mispredict,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredCount,
  output bht_state_e           dbg_state
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] table_q [ENTRIES];

  bht_state_e           state_q, state_d;
  logic [IDX_BITS-1:0]  ptr_q, ptr_d;
  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0]  pred_idx, res_idx;
  logic                 res_accept;
  logic [1:0]           res_cnt_next;

  // Single table write port, shared by INIT fill and RUN training.
  logic                 wr_en;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [1:0]           wr_data;

  // Word-aligned PCs: drop the byte offset; no tags, so upper bits alias.
  assign pred_idx = PredPC[IDX_BITS+1:2];
  assign res_idx  = ResPC[IDX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PredPC[31:IDX_BITS+2], PredPC[1:0],
                            ResPC[31:IDX_BITS+2], ResPC[1:0]};

  assign Ready      = (state_q == ST_RUN);
  assign res_accept = ResValid && Ready && is_cond_branch(ResOP);

  bht_counter_update u_cnt_upd (
    .cnt      (table_q[res_idx]),
    .taken    (ResTaken),
    .cnt_next (res_cnt_next)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    wr_en         = 1'b0;
    wr_idx        = res_idx;
    wr_data       = res_cnt_next;
    pred_valid_d  = 1'b0;
    pred_taken_d  = 1'b0;
    mispredict_d  = 1'b0;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_idx  = ptr_q;
        wr_data = BHT_INIT_VAL;
        ptr_d   = ptr_q + IDX_BITS'(1);
        if (&ptr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Read uses the registered table, so a same-cycle write to the same
        // entry is seen by the next request only (read-before-write).
        pred_valid_d = PredReq;
        pred_taken_d = PredReq & table_q[pred_idx][1];
        if (res_accept) begin
          wr_en = 1'b1;
          if (~&branch_cnt_q) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
          if (ResTaken != ResPredicted) begin
            mispredict_d = 1'b1;
            if (~&mispred_cnt_q) mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_INIT;
      ptr_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      mispredict_q  <= mispredict_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Table contents need no reset: INIT overwrites every entry before use.
  always_ff @(posedge CLK) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

  assign PredValid    = pred_valid_q;
  assign PredTaken    = pred_taken_q;
  assign Mispredict   = mispredict_q;
  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;
  import branch_history_table_pkg::*;

  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic          Ready;
  logic          PredReq = 1'b0;
  logic [31:0]   PredPC = '0;
  logic          PredValid, PredTaken;
  logic          ResValid = 1'b0;
  logic [31:0]   ResPC = '0;
  logic [5:0]    ResOP = '0;
  logic          ResTaken = 1'b0;
  logic          ResPredicted = 1'b0;
  logic          Mispredict;
  logic [CW-1:0] BranchCount, MispredCount;
  bht_state_e    dbg_state;

  branch_history_table #(.IDX_BITS(6), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .Ready(Ready),
    .PredReq(PredReq), .PredPC(PredPC), .PredValid(PredValid), .PredTaken(PredTaken),
    .ResValid(ResValid), .ResPC(ResPC), .ResOP(ResOP), .ResTaken(ResTaken),
    .ResPredicted(ResPredicted), .Mispredict(Mispredict),
    .BranchCount(BranchCount), .MispredCount(MispredCount), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [0:0]  pred_q[$];           // expected PredTaken per request
  logic [64:0] res_q[$];            // {Mispredict, BranchCount, MispredCount}
  logic [CW-1:0] exp_bc = '0;
  logic [CW-1:0] exp_mc = '0;
  logic          res_seen;
  logic [0:0]    mon_pred;
  logic [64:0]   mon_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge RST_N)
    if (!RST_N) res_seen <= 1'b0;
    else        res_seen <= ResValid;

  // Monitor: compares whenever the DUT presents a prediction or a resolve result.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (PredValid) begin
        if (pred_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pred_unexpected: PredValid=1 with no request outstanding at %0t", $time);
        end else begin
          mon_pred = pred_q.pop_front();
          check("pred_taken", 64'(PredTaken), 64'(mon_pred));
        end
      end
      if (res_seen) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected: resolve result with nothing expected at %0t", $time);
        end else begin
          mon_res = res_q.pop_front();
          check("mispredict",    64'(Mispredict),   64'(mon_res[64]));
          check("branch_count",  64'(BranchCount),  64'(mon_res[63:32]));
          check("mispred_count", 64'(MispredCount), 64'(mon_res[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic pr, input logic [31:0] ppc, input logic pv_exp, input logic pt_exp,
                      input logic rv, input logic [31:0] rpc, input logic [5:0] op,
                      input logic rt, input logic rp, input logic acc_exp, input logic mp_exp);
    PredReq = pr; PredPC = ppc;
    ResValid = rv; ResPC = rpc; ResOP = op; ResTaken = rt; ResPredicted = rp;
    if (pv_exp) pred_q.push_back(pt_exp);
    if (rv) begin
      if (acc_exp) begin
        if (exp_bc != '1) exp_bc++;
        if (mp_exp && exp_mc != '1) exp_mc++;
      end
      res_q.push_back({mp_exp & acc_exp, exp_bc, exp_mc});
    end
    @(posedge CLK); #1;
    PredReq = 1'b0; ResValid = 1'b0;
  endtask

  task automatic predict(input logic [31:0] pc, input logic exp_taken);
    step(1'b1, pc, 1'b1, exp_taken, 1'b0, 32'h0, OP_RTYPE, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [5:0] op, input logic rt,
                         input logic rp, input logic acc, input logic mp);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc, op, rt, rp, acc, mp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Counts cycles from reset release until Ready, bounded.
  task automatic wait_ready(input int start, output int n);
    n = start;
    while (!Ready && n < 200) begin @(posedge CLK); #1; n++; end
  endtask

  // ---------------- stimulus ----------------
  int n;
  initial begin
    // Reset state
    idle(3);
    check("rst_ready",      64'(Ready),        64'd0);
    check("rst_pred_valid", 64'(PredValid),    64'd0);
    check("rst_pred_taken", 64'(PredTaken),    64'd0);
    check("rst_mispredict", 64'(Mispredict),   64'd0);
    check("rst_bc",         64'(BranchCount),  64'd0);
    check("rst_mc",         64'(MispredCount), 64'd0);
    check("rst_state",      64'(dbg_state),    64'(ST_INIT));

    // Release; first INIT cycle carries an ignored predict and resolve.
    RST_N = 1'b1;
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h40, OP_BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_ready(1, n);
    check("init_cycles", 64'(n), 64'd64);
    check("run_state",   64'(dbg_state), 64'(ST_RUN));

    // Fresh table predicts not-taken everywhere
    predict(32'h0000_0000, 1'b0);
    predict(32'h0000_1234, 1'b0);
    predict(32'h0000_0040, 1'b0);

    // Train 0x40: 01 -> 10 -> 11
    resolve(32'h40, OP_BEQ, 1'b1, 1'b0, 1'b1, 1'b1);
    resolve(32'h40, OP_BEQ, 1'b1, 1'b0, 1'b1, 1'b1);
    predict(32'h40, 1'b1);

    // ST -> WT (still taken) -> WNT (not taken) -> back up and saturate
    resolve(32'h40, OP_BEQ, 1'b0, 1'b1, 1'b1, 1'b1);
    predict(32'h40, 1'b1);
    resolve(32'h40, OP_BEQ, 1'b0, 1'b1, 1'b1, 1'b1);
    predict(32'h40, 1'b0);
    resolve(32'h40, OP_BEQ, 1'b1, 1'b0, 1'b1, 1'b1);
    resolve(32'h40, OP_BEQ, 1'b1, 1'b1, 1'b1, 1'b0);
    resolve(32'h40, OP_BEQ, 1'b1, 1'b1, 1'b1, 1'b0);
    predict(32'h40, 1'b1);

    // Aliasing: 0x140 shares index 0x10 with 0x40
    predict(32'h140, 1'b1);

    // Non-branch opcodes are ignored entirely (two would drop 11 to 01)
    resolve(32'h40, OP_J,     1'b0, 1'b1, 1'b0, 1'b0);
    resolve(32'h40, OP_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0);
    predict(32'h40, 1'b1);

    // Other conditional branch opcodes are accepted
    resolve(32'h44, OP_BNE,  1'b1, 1'b1, 1'b1, 1'b0);
    predict(32'h44, 1'b1);
    resolve(32'h48, OP_BGEZ, 1'b0, 1'b0, 1'b1, 1'b0);
    predict(32'h48, 1'b0);
    resolve(32'h4C, OP_BLEZ, 1'b1, 1'b0, 1'b1, 1'b1);
    predict(32'h4C, 1'b1);
    resolve(32'h50, OP_BGTZ, 1'b1, 1'b0, 1'b1, 1'b1);
    predict(32'h50, 1'b1);

    // Same-cycle predict and resolve on 0x80 (WNT): read-before-write
    step(1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h80, OP_BEQ, 1'b1, 1'b0, 1'b1, 1'b1);
    predict(32'h80, 1'b1);

    // Same-cycle predict and resolve on different indices
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 32'h84, OP_BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
    predict(32'h84, 1'b0);
    idle(2);

    // Reset again, then reset mid-INIT at cycle 30
    RST_N = 1'b0; exp_bc = '0; exp_mc = '0;
    idle(2);
    RST_N = 1'b1;
    idle(30);
    check("mid_init_ready", 64'(Ready), 64'd0);
    RST_N = 1'b0;
    #1;
    check("mid_rst_state", 64'(dbg_state), 64'(ST_INIT));
    check("mid_rst_bc",    64'(BranchCount), 64'd0);
    check("mid_rst_mc",    64'(MispredCount), 64'd0);
    RST_N = 1'b1;
    wait_ready(0, n);
    check("reinit_cycles", 64'(n), 64'd64);

    // Table was reinitialised: trained entries are back to WNT
    predict(32'h40, 1'b0);
    predict(32'h80, 1'b0);
    idle(3);

    check("pred_q_drained", 64'(pred_q.size()), 64'd0);
    check("res_q_drained",  64'(res_q.size()),  64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time budget");
    $fatal(1, "timeout");
  end

endmodule
